// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion controller: FSM state
// encoding, default resolution / sampling length and counter width.
package sar_pkg;

  localparam int SAR_STATE_W     = 3;
  localparam int SAR_NBIT_DEF    = 10;
  localparam int SAR_SMP_CYC_DEF = 2;
  localparam int SAR_CNT_W       = 4;

  typedef enum logic [SAR_STATE_W-1:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } sar_state_e;

endpackage

// File: rtl/sar_smp_cnt.sv
// Sampling-phase down-counter: loaded on entry to the sampling phase,
// decremented each sampling cycle, flags terminal count at zero.
module sar_smp_cnt
  import sar_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 dec,
  input  logic [SAR_CNT_W-1:0] init,
  output logic                 tc
);

  logic [SAR_CNT_W-1:0] cnt;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= init;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/sar_ctrl.sv
// SAR ADC conversion controller: sample, then one strobe/wait trial per
// bit (MSB first, SWP[0] is the MSB), then a one-cycle FINAL pulse.
// Optional macro SAR_AUTO_RESTART_EN: DONE goes straight back to SAMPLE
// while EN is high, giving continuous conversion.
module sar_ctrl
  import sar_pkg::*;
#(
  parameter int NBIT    = SAR_NBIT_DEF,
  parameter int SMP_CYC = SAR_SMP_CYC_DEF
) (
  input  logic            CKS,
  input  logic            RST,
  input  logic            EN,
  input  logic            START,
  input  logic            CMP_OUT,
  input  logic            CMP_RDY,
  output logic            SMP,
  output logic            CMP_CK,
  output logic [0:NBIT-1] SWP,
  output logic            FINAL,
  output logic            BUSY
);

  localparam int KW = (NBIT > 1) ? $clog2(NBIT) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NBIT - 1);
  localparam logic [SAR_CNT_W-1:0] SMP_INIT = SAR_CNT_W'(SMP_CYC - 1);

  sar_state_e           state;
  sar_state_e           nextState;
  logic [KW-1:0]        k;
  logic                 cntLoad;
  logic                 cntDec;
  logic                 cntTc;
  logic [SAR_CNT_W-1:0] cntInit;
  logic                 goSample;

  sar_smp_cnt u_smp_cnt (
    .clk  (CKS),
    .rst  (RST),
    .load (cntLoad),
    .dec  (cntDec),
    .init (cntInit),
    .tc   (cntTc)
  );

  // State register; reset overrides everything, including a live conversion.
  always_ff @(posedge CKS) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and counter control; EN low aborts to IDLE from any state.
  always_comb begin
    nextState = state;
    cntLoad   = 1'b0;
    cntDec    = 1'b0;
    cntInit   = '0;
    goSample  = 1'b0;
    if (!EN) begin
      nextState = IDLE;
      cntLoad   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            goSample = 1'b1;
          end
        end
        SAMPLE: begin
          if (cntTc) begin
            nextState = STROBE;
          end else begin
            cntDec = 1'b1;
          end
        end
        STROBE: begin
          nextState = WAIT;
        end
        WAIT: begin
          if (CMP_RDY) begin
            nextState = (k == KLAST) ? DONE : STROBE;
          end
        end
        DONE: begin
`ifdef SAR_AUTO_RESTART_EN
          goSample = 1'b1;
`else
          nextState = IDLE;
`endif
        end
        default: begin
          nextState = IDLE;
        end
      endcase
    end
    if (goSample) begin
      nextState = SAMPLE;
      cntLoad   = 1'b1;
      cntInit   = SMP_INIT;
    end
  end

  // Successive-approximation register: set the trial bit, then resolve it
  // from the comparator and set the next trial; the result is held in IDLE.
  always_ff @(posedge CKS) begin
    if (RST || !EN) begin
      SWP <= '0;
      k   <= '0;
    end else if (goSample) begin
      SWP <= '0;
      k   <= '0;
    end else if ((state == SAMPLE) && cntTc) begin
      SWP[0] <= 1'b1;
      k      <= '0;
    end else if ((state == WAIT) && CMP_RDY) begin
      SWP[k] <= CMP_OUT;
      if (k != KLAST) begin
        SWP[k + 1'b1] <= 1'b1;
        k             <= k + 1'b1;
      end
    end
  end

  assign SMP    = (state == SAMPLE);
  assign CMP_CK = (state == STROBE);
  assign FINAL  = (state == DONE);
  assign BUSY   = (state != IDLE);

endmodule

// File: tb/tb_sar_ctrl.sv
// Testbench for sar_ctrl: directed conversions against a behavioural
// comparator; expected codes/latencies go into a scoreboard queue that a
// monitor drains on every FINAL pulse.
module tb_sar_ctrl;

  localparam int NBIT = 10;

  typedef struct {
    logic [0:NBIT-1] code;
    int              startCyc;
    int              lat;
  } exp_t;

  logic            CKS;
  logic            RST;
  logic            EN;
  logic            START;
  logic            CMP_OUT;
  logic            CMP_RDY;
  logic            SMP;
  logic            CMP_CK;
  logic [0:NBIT-1] SWP;
  logic            FINAL;
  logic            BUSY;

  logic            cmpRdyModel;
  logic            spurRdy;
  logic [0:NBIT-1] patBits;
  exp_t            sbq[$];
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              ckCount = 0;
  int              finalCount = 0;
  int              expFinals = 0;
  int              bitIdx = 0;
  int              cmpDelay = 0;

  assign CMP_RDY = cmpRdyModel | spurRdy;

  sar_ctrl #(.NBIT(NBIT), .SMP_CYC(2)) dut (
    .CKS     (CKS),
    .RST     (RST),
    .EN      (EN),
    .START   (START),
    .CMP_OUT (CMP_OUT),
    .CMP_RDY (CMP_RDY),
    .SMP     (SMP),
    .CMP_CK  (CMP_CK),
    .SWP     (SWP),
    .FINAL   (FINAL),
    .BUSY    (BUSY)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    CKS = 1'b0;
    forever #5 CKS = ~CKS;
  end

  // Rising-edge counter used to time START-to-FINAL latency.
  always @(posedge CKS) begin
    cyc <= cyc + 1;
  end

  // Single comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  // Comparator model: answers each strobe after cmpDelay extra wait cycles
  // with the next bit of patBits, as a one-cycle CMP_RDY pulse.
  initial begin
    logic nb;
    cmpRdyModel = 1'b0;
    CMP_OUT     = 1'b0;
    forever begin
      @(negedge CKS);
      if (CMP_CK === 1'b1) begin
        ckCount++;
        nb = (bitIdx < NBIT) ? patBits[bitIdx] : 1'b0;
        bitIdx++;
        @(posedge CKS);
        repeat (cmpDelay) @(posedge CKS);
        #1;
        cmpRdyModel = 1'b1;
        CMP_OUT     = nb;
        @(posedge CKS);
        #1;
        cmpRdyModel = 1'b0;
      end
    end
  end

  // Monitor: every FINAL cycle must match the oldest scoreboard entry.
  initial begin
    forever begin
      @(negedge CKS);
      if (FINAL === 1'b1) begin
        exp_t e;
        finalCount++;
        if (sbq.size() == 0) begin
          checkOutput("unexpected FINAL", FINAL, 1'b0);
        end else begin
          e = sbq.pop_front();
          checkOutput("result code", SWP, e.code);
          checkOutput("START-to-FINAL latency", cyc - e.startCyc, e.lat);
        end
      end
    end
  end

  // Issue one START; when a result is expected, queue code and latency.
  task automatic applyStimulus(input logic [0:NBIT-1] pat, input int dly,
                               input int lat, input bit expectDone);
    exp_t e;
    @(negedge CKS);
    bitIdx   = 0;
    ckCount  = 0;
    patBits  = pat;
    cmpDelay = dly;
    START    = 1'b1;
    if (expectDone) begin
      e.code     = pat;
      e.startCyc = cyc;
      e.lat      = lat;
      sbq.push_back(e);
      expFinals++;
    end
    @(negedge CKS);
    START = 1'b0;
  endtask

  // Wait (bounded) for the next FINAL, then check the post-conversion state.
  task automatic waitConv(input int bound, input logic [0:NBIT-1] pat);
    int target;
    bit seen;
    target = finalCount + 1;
    seen   = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge CKS);
      #2;
      if (finalCount >= target) seen = 1'b1;
    end
    checkOutput("FINAL within bound", seen, 1'b1);
`ifdef SAR_AUTO_RESTART_EN
    @(negedge CKS);
    checkOutput("restart SMP cycle 1", SMP, 1'b1);
    @(negedge CKS);
    checkOutput("restart SMP cycle 2", SMP, 1'b1);
    EN = 1'b0;
    @(negedge CKS);
    EN = 1'b1;
`else
    @(negedge CKS);
    checkOutput("idle after FINAL", BUSY, 1'b0);
    checkOutput("SWP held in IDLE", SWP, pat);
`endif
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    RST     = 1'b1;
    EN      = 1'b1;
    START   = 1'b0;
    spurRdy = 1'b0;
    patBits = '0;
    repeat (3) @(negedge CKS);
    checkOutput("reset SMP", SMP, 1'b0);
    checkOutput("reset CMP_CK", CMP_CK, 1'b0);
    checkOutput("reset FINAL", FINAL, 1'b0);
    checkOutput("reset BUSY", BUSY, 1'b0);
    checkOutput("reset SWP", SWP, '0);
    RST = 1'b0;

    // Zero-wait comparator, mixed pattern: 23-cycle latency.
    applyStimulus(10'b1011001010, 0, 23, 1'b1);
    waitConv(60, 10'b1011001010);
    checkOutput("strobes zero-wait", ckCount, 10);

    // Three-cycle comparator delay, all ones: 53-cycle latency.
    applyStimulus(10'b1111111111, 3, 53, 1'b1);
    waitConv(100, 10'b1111111111);
    checkOutput("strobes delay-3", ckCount, 10);

    // All zeros with one-cycle delay: 1+2+10*3 = 33.
    applyStimulus(10'b0000000000, 1, 33, 1'b1);
    waitConv(80, 10'b0000000000);

    // Abort with EN low while waiting on bit 4.
    applyStimulus(10'b1100110011, 3, 0, 1'b0);
    for (int i = 0; i < 100 && ckCount < 5; i++) begin
      @(negedge CKS);
      #2;
    end
    checkOutput("reached bit 4 strobe", ckCount, 5);
    @(negedge CKS);
    EN = 1'b0;
    @(negedge CKS);
    checkOutput("abort BUSY", BUSY, 1'b0);
    checkOutput("abort SWP", SWP, '0);
    checkOutput("abort SMP", SMP, 1'b0);
    checkOutput("abort CMP_CK", CMP_CK, 1'b0);
    EN = 1'b1;
    repeat (8) @(negedge CKS);
    checkOutput("still idle after abort", BUSY, 1'b0);
    applyStimulus(10'b0101010110, 0, 23, 1'b1);
    waitConv(60, 10'b0101010110);

    // Reset during SAMPLE with START held high.
    @(negedge CKS);
    START = 1'b1;
    @(negedge CKS);
    RST = 1'b1;
    @(negedge CKS);
    checkOutput("reset mid SWP", SWP, '0);
    checkOutput("reset mid FINAL", FINAL, 1'b0);
    checkOutput("reset mid CMP_CK", CMP_CK, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("reset held BUSY", BUSY, 1'b0);
      checkOutput("reset held SMP", SMP, 1'b0);
      @(negedge CKS);
    end
    RST   = 1'b0;
    START = 1'b0;
    @(negedge CKS);
    checkOutput("idle after reset release", BUSY, 1'b0);

    // Spurious CMP_RDY in SAMPLE and during the strobe, plus START pulses
    // while busy: result, latency and FINAL count must be unaffected.
    applyStimulus(10'b1100101101, 3, 53, 1'b1);
    spurRdy = 1'b1;
    @(negedge CKS);
    spurRdy = 1'b0;
    @(negedge CKS);
    spurRdy = 1'b1;
    @(negedge CKS);
    spurRdy = 1'b0;
    @(negedge CKS);
    START = 1'b1;
    @(negedge CKS);
    START = 1'b0;
    repeat (4) @(negedge CKS);
    START = 1'b1;
    @(negedge CKS);
    START = 1'b0;
    waitConv(100, 10'b1100101101);
    checkOutput("strobes with spurious RDY", ckCount, 10);

    // START together with EN falling stays in IDLE.
    @(negedge CKS);
    EN    = 1'b0;
    START = 1'b1;
    @(negedge CKS);
    checkOutput("START with EN low", BUSY, 1'b0);
    START = 1'b0;
    EN    = 1'b1;

    // No further conversion without a new START.
    repeat (6) @(negedge CKS);
    checkOutput("no conversion without START", BUSY, 1'b0);
    checkOutput("scoreboard drained", sbq.size(), 0);
    checkOutput("FINAL pulse count", finalCount, expFinals);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_ctrl.md
SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 The module SHALL have parameter NBIT, default 10, meaning conversion resolution; index 0 is the MSB.
REQ-002 The module SHALL have parameter SMP_CYC, default 2, meaning sampling-phase length in clock cycles (legal range 1..15).
REQ-003 The module SHALL have port CKS, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port EN, input, 1 bit: converter enable; low forces IDLE on the next edge.
REQ-006 The module SHALL have port START, input, 1 bit: conversion request, sampled in IDLE only.
REQ-007 The module SHALL have port CMP_OUT, input, 1 bit: comparator decision, 1 = input above DAC trial level.
REQ-008 The module SHALL have port CMP_RDY, input, 1 bit: comparator decision valid, a single-cycle pulse.
REQ-009 The module SHALL have port SMP, output, 1 bit: sampling-switch control, high during SAMPLE.
REQ-010 The module SHALL have port CMP_CK, output, 1 bit: comparator strobe, a single-cycle pulse per bit trial.
REQ-011 The module SHALL have port SWP, output, [0:NBIT-1]: DAC switch code, the trial word plus resolved bits.
REQ-012 The module SHALL have port FINAL, output, 1 bit: conversion complete, high for exactly one cycle.
REQ-013 The module SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SAMPLE, STROBE, WAIT, DONE, all registered.
REQ-015 In IDLE, START=1 with EN=1 SHALL move to SAMPLE, load the sample counter with SMP_CYC-1, and clear SWP to all zeros.
REQ-016 SAMPLE SHALL assert SMP for exactly SMP_CYC cycles, then move to STROBE with bit index k=0 and SWP[0]=1 (trial).
REQ-017 STROBE SHALL assert CMP_CK for one cycle, then move to WAIT.
REQ-018 In WAIT, CMP_RDY=1 SHALL set SWP[k]=CMP_OUT (keep on 1, clear on 0). If k<NBIT-1, it SHALL also set SWP[k+1]=1, increment k, and return to STROBE; otherwise it SHALL go to DONE.
REQ-019 CMP_RDY in any state other than WAIT SHALL be ignored.
REQ-020 CMP_RDY coincident with the CMP_CK cycle SHALL be ignored; only WAIT-state CMP_RDY counts.
REQ-021 DONE SHALL assert FINAL for one cycle with SWP holding the complete code, then return to IDLE.
REQ-022 SWP SHALL hold its final value in IDLE until the next SAMPLE entry clears it.
REQ-023 Latency from START to FINAL SHALL be 1 + SMP_CYC + sum over NBIT bits of (2 + comparator wait) cycles; with zero-wait comparator (CMP_RDY the cycle after CMP_CK) and defaults, this is 1+2+20 = 23 cycles.
REQ-024 EN=0 in any state SHALL return to IDLE next edge, deassert SMP, CMP_CK, BUSY and FINAL, and clear SWP; no FINAL is produced for an aborted conversion.
REQ-025 START while BUSY=1 SHALL be ignored (not queued).
REQ-026 START and EN falling in the same cycle SHALL remain in IDLE.

Reset
REQ-027 RST=1 at a CKS edge SHALL force state IDLE, k=0, sample counter 0, SWP=0, and SMP=CMP_CK=FINAL=BUSY=0.
REQ-028 RST SHALL take priority over EN and START, including mid-conversion.

Configuration
REQ-029 With macro SAR_AUTO_RESTART_EN defined, DONE SHALL go directly to SAMPLE when EN=1 (continuous conversion), and FINAL SHALL still pulse once per conversion.
REQ-030 Without SAR_AUTO_RESTART_EN, DONE SHALL always go to IDLE, and each conversion SHALL require a START.

Structure
REQ-031 Package sar_pkg SHALL hold the FSM state enum, the default NBIT and SMP_CYC constants, and the state encoding width.
REQ-032 The sample-phase counter SHALL be a sub-module sar_smp_cnt (load, decrement, terminal-count flag); everything else stays in sar_ctrl.

Verification
REQ-033 Zero-wait comparator, CMP_OUT pattern 1,0,1,1,0,0,1,0,1,0 -> FINAL at cycle 23 after START, SWP=10'b1011001010, one FINAL pulse.
REQ-034 Comparator with a 3-cycle CMP_RDY delay per bit, all CMP_OUT=1 -> SWP=10'b1111111111, FINAL at cycle 1+2+10*5=53, exactly 10 CMP_CK pulses.
REQ-035 EN dropped during WAIT of bit 4 -> IDLE next cycle, SWP=0, no FINAL; a following START converts normally.
REQ-036 RST asserted during SAMPLE with START held high -> all outputs 0 next cycle, and no conversion starts while RST=1.
REQ-037 START pulses during BUSY plus a spurious CMP_RDY in SAMPLE -> the result is unaffected and only one FINAL occurs.
REQ-038 With SAR_AUTO_RESTART_EN defined, a single START -> back-to-back conversions, SMP high 2 cycles right after each FINAL; without the macro, a single START -> one conversion, then IDLE.
